// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
// Declares the writeback request struct and the hazard address-match helper.
package rf_wb_arbiter_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned DataW    = 64;

  typedef struct packed {
    logic [RegAddrW-1:0] waddr;
    logic [DataW-1:0]    wdata;
  } wb_req_t;

  // A pending write to x0 never creates a hazard.
  function automatic logic addr_hit(input logic [RegAddrW-1:0] raddr,
                                    input logic                vld,
                                    input logic [RegAddrW-1:0] waddr);
    return vld && (raddr != '0) && (raddr == waddr);
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundles the writeback sources, the register file write port and the decode hazard check.
// The master drives requests and read addresses; the slave is the arbiter.
interface rf_wb_arbiter_if;
  import rf_wb_arbiter_pkg::*;

  logic                a_valid;
  logic                a_ready;
  logic [RegAddrW-1:0] a_waddr;
  logic [DataW-1:0]    a_wdata;

  logic                b_valid;
  logic                b_ready;
  logic [RegAddrW-1:0] b_waddr;
  logic [DataW-1:0]    b_wdata;

  logic                rf_wen;
  logic [RegAddrW-1:0] rf_waddr;
  logic [DataW-1:0]    rf_wdata;

  logic [RegAddrW-1:0] chk_raddr1;
  logic [RegAddrW-1:0] chk_raddr2;
  logic                hazard1;
  logic                hazard2;
  logic                b_pending;

  modport master (
    output a_valid, a_waddr, a_wdata,
    output b_valid, b_waddr, b_wdata,
    output chk_raddr1, chk_raddr2,
    input  a_ready, b_ready,
    input  rf_wen, rf_waddr, rf_wdata,
    input  hazard1, hazard2, b_pending
  );

  modport slave (
    input  a_valid, a_waddr, a_wdata,
    input  b_valid, b_waddr, b_wdata,
    input  chk_raddr1, chk_raddr2,
    output a_ready, b_ready,
    output rf_wen, rf_waddr, rf_wdata,
    output hazard1, hazard2, b_pending
  );

endinterface

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// Source-B writeback FIFO with wrap-bit pointers.
// Exposes per-entry valid and destination address so the hazard check can scan it.
module rf_wb_arbiter_wb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               i_push,
  input  wb_req_t                            i_push_data,
  input  logic                               i_pop,
  output wb_req_t                            o_head,
  output logic                               o_full,
  output logic                               o_empty,
  output logic [DEPTH-1:0]                   o_ent_valid,
  output logic [DEPTH-1:0][RegAddrW-1:0]     o_ent_waddr
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  wb_req_t         r_mem [DEPTH];
  logic [PtrW:0]   r_wptr;
  logic [PtrW:0]   r_rptr;
  logic [PtrW:0]   w_count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + (PtrW+1)'(1);
      if (i_pop)  r_rptr <= r_rptr + (PtrW+1)'(1);
    end
  end

  // Storage needs no reset: only entries between the pointers are ever observed.
  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wptr[PtrW-1:0]] <= i_push_data;
  end

  assign w_count = r_wptr - r_rptr;
  assign o_head  = r_mem[r_rptr[PtrW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PtrW] != r_rptr[PtrW]) &&
                   (r_wptr[PtrW-1:0] == r_rptr[PtrW-1:0]);

  // Slot i is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    o_ent_valid = '0;
    o_ent_waddr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_ent_valid[i] = ({1'b0, PtrW'(i) - r_rptr[PtrW-1:0]} < w_count);
      o_ent_waddr[i] = r_mem[i].waddr;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline (A) and buffered
// multi-cycle (B) writeback, with anti-starvation, a registered write stage and RAW hazard flags.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  rf_wb_arbiter_if.slave   bus
);

  localparam int unsigned    StW       = $clog2(STARVE_MAX + 1);
  localparam logic [StW-1:0] StarveLim = StW'(STARVE_MAX);

  logic                           w_full;
  logic                           w_empty;
  logic                           w_push;
  logic                           w_pop;
  logic                           w_force;
  logic                           w_a_win;
  logic                           w_grant;
  logic                           w_issue;
  wb_req_t                        w_head;
  wb_req_t                        w_push_data;
  wb_req_t                        w_win;
  logic [DEPTH-1:0]               w_ent_valid;
  logic [DEPTH-1:0][RegAddrW-1:0] w_ent_waddr;
  logic                           w_hit1;
  logic                           w_hit2;

  logic [StW-1:0]                 r_starve;
  logic                           r_out_valid;
  logic [RegAddrW-1:0]            r_out_waddr;
  logic [DataW-1:0]               r_out_wdata;

  assign w_push_data = {bus.b_waddr, bus.b_wdata};
  assign w_push      = bus.b_valid && !w_full;

  rf_wb_arbiter_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_ent_valid (w_ent_valid),
    .o_ent_waddr (w_ent_waddr)
  );

  // Fixed priority to A unless B has waited STARVE_MAX cycles behind it.
  assign w_force = (r_starve == StarveLim) && !w_empty;
  assign w_a_win = bus.a_valid && !w_force;
  assign w_pop   = !w_empty && !w_a_win;
  assign w_grant = w_a_win || w_pop;
  assign w_win   = w_a_win ? {bus.a_waddr, bus.a_wdata} : w_head;
  assign w_issue = w_grant && (w_win.waddr != '0);

  assign bus.a_ready   = !w_force;
  assign bus.b_ready   = !w_full;
  assign bus.b_pending = !w_empty;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_starve <= '0;
    end else if (w_empty || w_pop) begin
      r_starve <= '0;
    end else if (w_a_win && (r_starve != StarveLim)) begin
      r_starve <= r_starve + StW'(1);
    end
  end

  // Address/data hold their last issued value while the write enable is low.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_waddr <= '0;
      r_out_wdata <= '0;
    end else begin
      r_out_valid <= w_issue;
      if (w_issue) begin
        r_out_waddr <= w_win.waddr;
        r_out_wdata <= w_win.wdata;
      end
    end
  end

  assign bus.rf_wen   = r_out_valid;
  assign bus.rf_waddr = r_out_waddr;
  assign bus.rf_wdata = r_out_wdata;

  always_comb begin
    w_hit1 = addr_hit(bus.chk_raddr1, r_out_valid, r_out_waddr);
    w_hit2 = addr_hit(bus.chk_raddr2, r_out_valid, r_out_waddr);
    for (int i = 0; i < DEPTH; i++) begin
      w_hit1 = w_hit1 | addr_hit(bus.chk_raddr1, w_ent_valid[i], w_ent_waddr[i]);
      w_hit2 = w_hit2 | addr_hit(bus.chk_raddr2, w_ent_valid[i], w_ent_waddr[i]);
    end
  end

  assign bus.hazard1 = w_hit1;
  assign bus.hazard2 = w_hit2;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomised scoreboard bench for rf_wb_arbiter against a queue-level reference model.
// The driver predicts handshakes and hazards; a monitor checks the register-file write stream.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned STARVE_MAX = 8;

  typedef struct {
    int                  due;
    bit                  rst;
    logic [RegAddrW-1:0] a;
    logic [DataW-1:0]    d;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  exp_t    exp_q[$];
  wb_req_t mq[$];
  wb_req_t a_script[$];
  wb_req_t b_script[$];

  int unsigned         starve = 0;
  bit                  cur_v  = 0;
  logic [RegAddrW-1:0] cur_a  = '0;
  bit                  a_pend = 0;
  bit                  b_pend = 0;
  wb_req_t             a_req;
  wb_req_t             b_req;
  int unsigned         pa = 0;
  int unsigned         pb = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic wb_req_t rand_req();
    wb_req_t r;
    r.waddr = RegAddrW'($urandom_range(7));
    r.wdata = {$urandom, $urandom};
    return r;
  endfunction

  function automatic bit exp_haz(input logic [RegAddrW-1:0] ra);
    if (ra == '0) return 1'b0;
    if (cur_v && cur_a == ra) return 1'b1;
    foreach (mq[i]) if (mq[i].waddr == ra) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_monitor();
    logic [RegAddrW-1:0] last_a;
    logic [DataW-1:0]    last_d;
    last_a = '0;
    last_d = '0;
    forever begin
      @(negedge clock);
      if (cyc >= 1) begin
        exp_t e;
        bit   due;
        due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        if (due) begin
          e = exp_q.pop_front();
          if (e.rst) begin
            last_a = '0;
            last_d = '0;
            chk("rf_wen_after_reset", bus.rf_wen, 0);
          end else begin
            chk("rf_wen_write", bus.rf_wen, 1);
            last_a = e.a;
            last_d = e.d;
          end
        end else begin
          chk("rf_wen_idle", bus.rf_wen, 0);
        end
        chk("rf_waddr", bus.rf_waddr, last_a);
        chk("rf_wdata", bus.rf_wdata, last_d);
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, check and advance the model just after.
  task automatic step(input bit rst);
    @(negedge clock);
    if (!a_pend) begin
      if (a_script.size() > 0) begin
        a_req = a_script.pop_front(); a_pend = 1;
      end else if (!rst && $urandom_range(99) < pa) begin
        a_req = rand_req(); a_pend = 1;
      end
    end
    if (!b_pend) begin
      if (b_script.size() > 0) begin
        b_req = b_script.pop_front(); b_pend = 1;
      end else if (!rst && $urandom_range(99) < pb) begin
        b_req = rand_req(); b_pend = 1;
      end
    end
    reset_n        = !rst;
    bus.a_valid    = a_pend && !rst;
    bus.a_waddr    = a_req.waddr;
    bus.a_wdata    = a_req.wdata;
    bus.b_valid    = b_pend && !rst;
    bus.b_waddr    = b_req.waddr;
    bus.b_wdata    = b_req.wdata;
    bus.chk_raddr1 = RegAddrW'($urandom_range(7));
    bus.chk_raddr2 = RegAddrW'($urandom_range(7));
    #1;
    if (rst) begin
      mq.delete();
      starve = 0;
      cur_v  = 0;
      exp_q.push_back('{due: cyc + 1, rst: 1'b1, a: '0, d: '0});
    end else begin
      bit      force_b;
      bit      b_rdy;
      bit      has_win;
      wb_req_t win;
      force_b = (starve == STARVE_MAX) && (mq.size() > 0);
      b_rdy   = (mq.size() < DEPTH);
      chk("a_ready",   bus.a_ready,   !force_b);
      chk("b_ready",   bus.b_ready,   b_rdy);
      chk("b_pending", bus.b_pending, mq.size() > 0);
      chk("hazard1",   bus.hazard1,   exp_haz(bus.chk_raddr1));
      chk("hazard2",   bus.hazard2,   exp_haz(bus.chk_raddr2));
      has_win = 0;
      win     = '0;
      if (force_b || (!a_pend && mq.size() > 0)) begin
        win = mq.pop_front(); has_win = 1; starve = 0;
      end else if (a_pend) begin
        win = a_req; has_win = 1; a_pend = 0;
        if (mq.size() == 0) starve = 0;
        else if (starve < STARVE_MAX) starve++;
      end else begin
        starve = 0;
      end
      cur_v = has_win && (win.waddr != '0);
      if (cur_v) begin
        cur_a = win.waddr;
        exp_q.push_back('{due: cyc + 1, rst: 1'b0, a: win.waddr, d: win.wdata});
      end
      if (b_pend && b_rdy) begin
        mq.push_back(b_req);
        b_pend = 0;
      end
    end
  endtask

  initial begin
    bus.a_valid = 0; bus.a_waddr = '0; bus.a_wdata = '0;
    bus.b_valid = 0; bus.b_waddr = '0; bus.b_wdata = '0;
    bus.chk_raddr1 = '0; bus.chk_raddr2 = '0;
    a_req = '0;
    b_req = '0;
    fork
      run_monitor();
    join_none

    repeat (2) step(1);

    // Single A write, then an A write to x0 that must be swallowed.
    a_script.push_back('{waddr: 5'd5, wdata: 64'hDEAD});
    repeat (3) step(0);
    a_script.push_back('{waddr: 5'd0, wdata: 64'h1234});
    repeat (3) step(0);

    // A saturating the port while B fills the FIFO and triggers anti-starvation.
    pa = 100; pb = 100;
    repeat (40) step(0);
    pa = 0; pb = 0;
    repeat (10) step(0);

    // In-order drain of B writes with a repeated destination.
    b_script.push_back('{waddr: 5'd3, wdata: 64'd1});
    b_script.push_back('{waddr: 5'd4, wdata: 64'd2});
    b_script.push_back('{waddr: 5'd3, wdata: 64'd3});
    repeat (12) step(0);

    // Reset while B entries are queued behind A.
    pa = 100; pb = 100;
    repeat (6) step(0);
    pa = 0; pb = 0;
    step(1);
    repeat (8) step(0);

    for (int r = 0; r < 20; r++) begin
      pa = $urandom_range(100);
      pb = $urandom_range(100);
      if ($urandom_range(3) == 0) step(1);
      repeat (100) step(0);
    end

    pa = 0; pb = 0;
    repeat (20) step(0);
    @(negedge clock);
    #2;
    chk("write_queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single write port of the 32x64 integer register file between two writeback sources.
- Source A is the main pipeline writeback (ALU/branch). Source B is the multi-cycle unit writeback (LSU/MDU).
- Source B results are buffered in a small FIFO. A fixed-priority policy with anti-starvation sequences the writes.
- Drives the register file write port through a registered stage and flags read-after-write hazards on still-pending writes to the decode stage.

Parameters:
- DEPTH, 4, source-B FIFO entries (power of two, >=2).
- STARVE_MAX, 8, consecutive cycles B may be blocked before A is forced to yield one cycle.

Ports:
- clock      input   1   system clock, all state on posedge
- reset_n    input   1   synchronous, active-low reset
- a_valid    input   1   source A writeback request
- a_ready    output  1   source A accepted this cycle
- a_waddr    input   5   source A destination register
- a_wdata    input   64  source A data
- b_valid    input   1   source B writeback request
- b_ready    output  1   FIFO can accept B this cycle
- b_waddr    input   5   source B destination register
- b_wdata    input   64  source B data
- rf_wen     output  1   register file write enable
- rf_waddr   output  5   register file write address
- rf_wdata   output  64  register file write data
- chk_raddr1 input   5   decode read address 1
- chk_raddr2 input   5   decode read address 2
- hazard1    output  1   chk_raddr1 targets a pending write
- hazard2    output  1   chk_raddr2 targets a pending write
- b_pending  output  1   FIFO non-empty

Behaviour:
- Reset (reset_n low at posedge): FIFO empty, output stage invalid, starve_cnt=0. Outputs reset to: rf_wen=0, rf_waddr=0, rf_wdata=0, b_pending=0, hazard1=hazard2=0. A reset asserted mid-operation discards buffered B entries.
- Handshakes: transfers occur at a posedge where valid&&ready. Senders hold valid and payload stable until the transfer.
- b_ready = !full. A push while full cannot occur.
- Simultaneous pop and push when full: b_ready stays 0 (b_ready is not computed from the pop). The B push is deferred to a later cycle.
- Grant per cycle, one winner only:
  - If starve_cnt==STARVE_MAX and FIFO is non-empty: pop B, a_ready=0.
  - Else if a_valid: a_ready=1, A wins.
  - Else if FIFO is non-empty: pop B. a_ready=1 in this case too; it is harmless because a_valid=0.
- The FIFO is never bypassed. A B request accepted in cycle N can pop no earlier than N+1.
- Output stage is registered. The winner of cycle N drives rf_wen/rf_waddr/rf_wdata during cycle N+1, and the write lands at the end of N+1.
  - rf_wen=1 only if the winner's waddr!=0. Writes to x0 are consumed (handshake completes) but never issued.
  - rf_waddr and rf_wdata hold their last value when rf_wen=0.
- starve_cnt:
  - Increments when FIFO is non-empty and A wins.
  - Clears to 0 on any B pop, or when the FIFO is empty.
  - Saturates at STARVE_MAX.
- FIFO ordering: B entries write in arrival order. The pointers are log2(DEPTH)+1 bits and wrap naturally. Full = MSBs differ and the low bits are equal.
- Hazards (combinational from registered state):
  - hazard1 = chk_raddr1!=0 && (raddr equals the waddr of any valid FIFO entry || raddr equals the waddr of the valid output stage).
  - hazard2 is defined the same way for chk_raddr2.
  - Source A in-flight requests are not tracked; the pipeline forwards those itself.
- Write ordering between A and B to the same register is the issuer's responsibility. Decode must stall on hazard* before issuing a younger writer.

Decomposition:
- Shared package: register-address width (5), data width (64), and a wb_req struct {waddr, wdata}.
- One sub-module: wb_fifo, a parameterised DEPTH FIFO. It has push/pop/full/empty and exposes per-entry valid+waddr for the hazard compare.
- The arbiter, starve counter, output stage and hazard logic stay in rf_wb_arbiter.

Test Plan:
- After reset, only A: a_valid with waddr=5, wdata=0xDEAD -> a_ready=1. In the next cycle: rf_wen=1, rf_waddr=5, rf_wdata=0xDEAD.
- x0 drop: A with waddr=0 -> a_ready=1, rf_wen stays 0. chk_raddr1=0 never raises hazard1.
- B fill:
  - With A idle-blocked (a_valid held continuously), push 4 B entries -> b_ready=0 after the 4th, and b_pending=1.
  - chk_raddr2 equal to any queued waddr -> hazard2=1.
- Starvation: A valid every cycle with B queued -> after 8 A grants, a_ready=0 for exactly one cycle. The oldest B entry is written in the following cycle, and starve_cnt returns to 0.
- Ordering and drain: push B writes to x3=1, x4=2, x3=3, then A goes idle -> rf writes occur in order 3,4,3 on consecutive cycles. hazard on x3 clears one cycle after the last write issues.
- Reset mid-drain: reset_n=0 with 3 entries queued -> the next cycle shows b_pending=0, rf_wen=0, and no queued writes are issued after release.
